user_gpio_wb_bank: RTL and testbench
====================================

Name: user_gpio_wb_bank

Overview:
- Parametrised Wishbone-slave GPIO bank for the user project area.
- Replaces hard-wired io_in/io_out/io_oeb pass-through with register-controlled per-pin output data and output-enable.
- Provides synchronised input sampling and per-pin edge-detect interrupts driving user_irq.
- Instantiated inside user_analog_project_wrapper on the digital GPIO slice.

Parameters:
- NUM_IO, 16, GPIO pins managed; legal 1..32.
- BASE_ADR, 32'h3000_0000, Wishbone base address; 64-byte window.
- SYNC_STAGES, 2, input synchroniser flops; legal 2..4.
- DEBOUNCE_CYCLES, 8, stable cycles required when debounce is compiled in; legal 2..255.

Ports:
- wb_clk_i  input  1  Sole clock, Wishbone clock.
- wb_rst_ni  input  1  Asynchronous active-low reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  Write enable.
- wbs_sel_i  input  4  Byte lane selects.
- wbs_adr_i  input  32  Byte address.
- wbs_dat_i  input  32  Write data.
- wbs_ack_o  output  1  Acknowledge.
- wbs_dat_o  output  32  Read data.
- io_in  input  NUM_IO  Pad inputs, asynchronous.
- io_out  output  NUM_IO  Pad output data.
- io_oeb  output  NUM_IO  Pad output enable, active-low.
- la_data_out  output  NUM_IO  Conditioned input snapshot for the logic analyser.
- user_irq  output  3  Interrupt lines.

Behaviour:

Reset:
- Asynchronous on wb_rst_ni low.
- Outputs: wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1 (all pins input), la_data_out=0, user_irq=0.
- All registers zero, except OEB, which resets to all 1.
- Synchroniser and edge history cleared.

Register map (offset from BASE_ADR; bits at or above NUM_IO read 0 and ignore writes):
- 0x00 OUT: RW; drives io_out.
- 0x04 OEB: RW; drives io_oeb.
- 0x08 IN: RO; conditioned input; writes ignored but acked.
- 0x0C IEN: RW; per-pin interrupt enable.
- 0x10 IEDGE: RW; per pin, 0 = rising, 1 = falling.
- 0x14 ISTAT: W1C; per-pin pending flag.
- 0x18 ID: RO; {16'hC0DE, 8'(NUM_IO), 8'h01}.
- 0x1C–0x3C: unmapped; reads 0, writes ignored, still acked.

Wishbone handshake:
- Request = cyc & stb & address inside [BASE_ADR, BASE_ADR+0x3F].
- wbs_ack_o asserts for exactly one cycle, the cycle after a request with ack currently low.
- ack is forced low the cycle after it was high; back-to-back requests therefore ack every other cycle.
- Addresses outside the window are never acked.
- Writes honour wbs_sel_i per byte lane and take effect at the ack edge.
- wbs_dat_o is registered, valid only while ack=1, and 0 otherwise.
- Read latency is 1 cycle.

Input path:
- io_in passes through SYNC_STAGES flops to give the conditioned value (see Optional Feature).
- IN and la_data_out equal the conditioned value.
- Latency io_in to IN is SYNC_STAGES cycles, without debounce.

Edge detect:
- prev register holds the last conditioned value.
- rise = cond & ~prev; fall = ~cond & prev.
- event[i] = IEDGE[i] ? fall[i] : rise[i].
- The first cycle after reset release only loads prev (a "primed" flag), so no spurious events occur.
- ISTAT[i] is set on event[i] regardless of IEN.
- Simultaneous set and W1C on the same bit in the same cycle: set wins.

IRQ outputs (registered, one cycle after ISTAT/IEN changes):
- user_irq[0] = |(ISTAT & IEN) over pins [NUM_IO/2-1:0].
- user_irq[1] = the same over pins [NUM_IO-1:NUM_IO/2].
- user_irq[2] = sticky access-error flag: set by a write to IN/ID or to an unmapped offset; cleared by writing 1 to bit 31 of ISTAT.

Reset mid-transaction:
- ack drops immediately; the pending write is discarded.

Optional Feature:
- Macro: USER_GPIO_DEBOUNCE_EN.
- Defined: each pin gets an 8-bit stability counter after the synchroniser.
  - The conditioned value updates only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any return to the old value resets the counter.
  - ID bit 8 reads 1.
- Undefined: conditioned value = synchroniser output, no counters are instantiated, and ID bit 8 reads 0.

Test Plan:
- Reset: assert wb_rst_ni low mid-cycle -> io_oeb=16'hFFFF, io_out=0, user_irq=0 asynchronously; read 0x18 -> 32'hC0DE_1001.
- Byte-lane write: OUT=0x0000_A5A5 with sel=4'b0001, then read -> 0x0000_00A5; io_out[7:0]=8'hA5 one cycle after ack.
- Rising IRQ: IEN=0x0001, IEDGE=0, drive io_in[0] 0→1 -> ISTAT=0x1 after SYNC_STAGES+1 cycles, user_irq[0]=1 one cycle later; W1C 0x1 -> user_irq[0]=0.
- Collision: W1C of bit 3 in the same cycle a falling event sets bit 3 (IEDGE[3]=1) -> ISTAT[3] stays 1.
- Address decode: access to BASE_ADR+0x40 -> no ack within 4 cycles; write to 0x08 -> acked, IN unchanged, user_irq[2]=1.
- Debounce (macro defined, DEBOUNCE_CYCLES=8): 5-cycle glitch on io_in[2] -> IN[2] unchanged, no event; 10-cycle pulse -> IN[2]=1 after 2+8 cycles.

Source files
------------

// File: rtl/user_gpio_wb_bank.sv
// Wishbone-slave GPIO bank: per-pin output data/enable, synchronised inputs, edge IRQs.
// Optional per-pin input debounce is compiled in with `define USER_GPIO_DEBOUNCE_EN.
module user_gpio_wb_bank #(
  parameter int          NUM_IO          = 16,
  parameter logic [31:0] BASE_ADR        = 32'h3000_0000,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [NUM_IO-1:0] la_data_out,
  output logic [2:0]        user_irq
);

  localparam int HALF = NUM_IO / 2;

  localparam logic [3:0] W_OUT   = 4'd0;
  localparam logic [3:0] W_OEB   = 4'd1;
  localparam logic [3:0] W_IN    = 4'd2;
  localparam logic [3:0] W_IEN   = 4'd3;
  localparam logic [3:0] W_IEDGE = 4'd4;
  localparam logic [3:0] W_ISTAT = 4'd5;
  localparam logic [3:0] W_ID    = 4'd6;

  if (NUM_IO < 1 || NUM_IO > 32) begin : g_bad_num_io
    $error("NUM_IO must be 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_dbnc
    $error("DEBOUNCE_CYCLES must be 2..255");
  end

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] oeb_q, oeb_d;
  logic [NUM_IO-1:0] ien_q, ien_d;
  logic [NUM_IO-1:0] iedge_q, iedge_d;
  logic [NUM_IO-1:0] istat_q, istat_d;
  logic [NUM_IO-1:0] prev_q;
  logic              primed_q;
  logic              err_q, err_d;
  logic [1:0]        irq_q, irq_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];

  logic [NUM_IO-1:0] sync_out, cond, evt, w1c, pend, lo_mask;
  logic [NUM_IO-1:0] wdat, wmask;
  logic [31:0]       be, rdata;
  logic [3:0]        word;
  logic              req, acc, wr;
  logic              unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  // Request only inside the 64-byte window; ack_q gating yields one ack per two cycles.
  assign req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:6] == BASE_ADR[31:6]);
  assign acc  = req & ~ack_q;
  assign wr   = acc & wbs_we_i;
  assign word = wbs_adr_i[5:2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign be[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
  end

  assign wmask    = be[NUM_IO-1:0];
  assign wdat     = wbs_dat_i[NUM_IO-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];

  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_lo
    assign lo_mask[gi] = (gi < HALF);
  end

`ifdef USER_GPIO_DEBOUNCE_EN
  localparam logic       DBNC_BIT = 1'b1;
  localparam logic [7:0] LIMIT    = 8'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_dbnc
    logic [7:0] cnt_q, cnt_d;
    logic       cond_q, cond_d;

    always_comb begin
      cnt_d  = '0;
      cond_d = cond_q;
      if (sync_out[gi] != cond_q) begin
        if (cnt_q == LIMIT) cond_d = sync_out[gi];
        else                cnt_d  = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
        cnt_q  <= '0;
        cond_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        cond_q <= cond_d;
      end
    end

    assign cond[gi] = cond_q;
  end
`else
  localparam logic DBNC_BIT = 1'b0;
  assign cond = sync_out;
`endif

  assign evt  = primed_q ? ((iedge_q & ~cond & prev_q) | (~iedge_q & cond & ~prev_q)) : '0;
  assign pend = istat_q & ien_q;

  always_comb begin
    rdata = '0;
    case (word)
      W_OUT:   rdata = 32'(out_q);
      W_OEB:   rdata = 32'(oeb_q);
      W_IN:    rdata = 32'(cond);
      W_IEN:   rdata = 32'(ien_q);
      W_IEDGE: rdata = 32'(iedge_q);
      W_ISTAT: rdata = 32'(istat_q);
      W_ID: begin
        rdata    = {16'hC0DE, 8'(NUM_IO), 8'h01};
        rdata[8] = DBNC_BIT;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d   = acc;
    dat_d   = (acc & ~wbs_we_i) ? rdata : '0;
    out_d   = out_q;
    oeb_d   = oeb_q;
    ien_d   = ien_q;
    iedge_d = iedge_q;
    w1c     = '0;
    err_d   = err_q;
    if (wr) begin
      case (word)
        W_OUT:   out_d   = (out_q   & ~wmask) | (wdat & wmask);
        W_OEB:   oeb_d   = (oeb_q   & ~wmask) | (wdat & wmask);
        W_IEN:   ien_d   = (ien_q   & ~wmask) | (wdat & wmask);
        W_IEDGE: iedge_d = (iedge_q & ~wmask) | (wdat & wmask);
        W_ISTAT: begin
          w1c = wdat & wmask;
          if (wbs_dat_i[31] && wbs_sel_i[3]) err_d = 1'b0;
        end
        default: err_d = 1'b1;  // IN, ID and the unmapped tail are not writable
      endcase
    end
    // A new event on the same bit outranks a simultaneous clear.
    istat_d = (istat_q & ~w1c) | evt;
    irq_d   = {|(pend & ~lo_mask), |(pend & lo_mask)};
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      out_q    <= '0;
      oeb_q    <= '1;
      ien_q    <= '0;
      iedge_q  <= '0;
      istat_q  <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      out_q    <= out_d;
      oeb_q    <= oeb_d;
      ien_q    <= ien_d;
      iedge_q  <= iedge_d;
      istat_q  <= istat_d;
      prev_q   <= cond;
      primed_q <= 1'b1;
      err_q    <= err_d;
      irq_q    <= irq_d;
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign io_out      = out_q;
  assign io_oeb      = oeb_q;
  assign la_data_out = cond;
  assign user_irq    = {err_q, irq_q};

endmodule

// File: tb/tb_user_gpio_wb_bank.sv
// Directed bench for user_gpio_wb_bank: register table plus IRQ, collision, decode and reset sequences.
module tb_user_gpio_wb_bank;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef USER_GPIO_DEBOUNCE_EN
  localparam int          CL     = 2 + 8;
  localparam logic [31:0] ID_EXP = 32'hC0DE_1101;
`else
  localparam int          CL     = 2;
  localparam logic [31:0] ID_EXP = 32'hC0DE_1001;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic [15:0] io_in, io_out, io_oeb, la;
  logic [2:0]  irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  user_gpio_wb_bank dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .la_data_out(la), .user_irq(irq)
  );

  typedef struct {
    logic        we;
    logic [7:0]  ofs;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [15:0] exp_out;
    logic [15:0] exp_oeb;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output logic acked);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin acked = 1'b1; rd = rdat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("wb we=%0d adr=%h sel=%b wdat=%h rdat=%h ack=%0d", w, a, s, d, rd, acked);
  endtask

  task automatic wr(input logic [7:0] ofs, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    logic        acked;
    xfer(1'b1, BASE + 32'(ofs), s, d, rd, acked);
    chk("write_ack", 32'(acked), 32'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] ofs, input logic [31:0] exp);
    logic [31:0] rd;
    logic        acked;
    xfer(1'b0, BASE + 32'(ofs), 4'hF, 32'h0, rd, acked);
    chk("read_ack", 32'(acked), 32'd1);
    chk(nm, rd, exp);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
    io_in = '0;

    tbl[0]  = '{1'b1, 8'h00, 4'b0001, 32'h0000_A5A5, 32'h0, 16'h00A5, 16'hFFFF};
    tbl[1]  = '{1'b0, 8'h00, 4'b1111, 32'h0, 32'h0000_00A5, 16'h00A5, 16'hFFFF};
    tbl[2]  = '{1'b1, 8'h00, 4'b1111, 32'h1234_5678, 32'h0, 16'h5678, 16'hFFFF};
    tbl[3]  = '{1'b0, 8'h00, 4'b1111, 32'h0, 32'h0000_5678, 16'h5678, 16'hFFFF};
    tbl[4]  = '{1'b1, 8'h00, 4'b0010, 32'hFFFF_0000, 32'h0, 16'h0078, 16'hFFFF};
    tbl[5]  = '{1'b0, 8'h00, 4'b1111, 32'h0, 32'h0000_0078, 16'h0078, 16'hFFFF};
    tbl[6]  = '{1'b1, 8'h04, 4'b1111, 32'h0000_00F0, 32'h0, 16'h0078, 16'h00F0};
    tbl[7]  = '{1'b0, 8'h04, 4'b1111, 32'h0, 32'h0000_00F0, 16'h0078, 16'h00F0};
    tbl[8]  = '{1'b1, 8'h0C, 4'b0011, 32'hFFFF_8001, 32'h0, 16'h0078, 16'h00F0};
    tbl[9]  = '{1'b0, 8'h0C, 4'b1111, 32'h0, 32'h0000_8001, 16'h0078, 16'h00F0};
    tbl[10] = '{1'b1, 8'h10, 4'b1111, 32'h0000_0008, 32'h0, 16'h0078, 16'h00F0};
    tbl[11] = '{1'b0, 8'h10, 4'b1111, 32'h0, 32'h0000_0008, 16'h0078, 16'h00F0};
    tbl[12] = '{1'b0, 8'h18, 4'b1111, 32'h0, ID_EXP,        16'h0078, 16'h00F0};
    tbl[13] = '{1'b0, 8'h1C, 4'b1111, 32'h0, 32'h0,         16'h0078, 16'h00F0};
    tbl[14] = '{1'b0, 8'h3C, 4'b1111, 32'h0, 32'h0,         16'h0078, 16'h00F0};
    tbl[15] = '{1'b0, 8'h14, 4'b1111, 32'h0, 32'h0,         16'h0078, 16'h00F0};

    // Reset state
    #12;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_out", 32'(io_out), 32'h0);
    chk("rst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    chk("rst_la", 32'(la), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Register table
    for (int i = 0; i < 16; i++) begin
      logic [31:0] rd;
      logic        acked;
      xfer(tbl[i].we, BASE + 32'(tbl[i].ofs), tbl[i].sel, tbl[i].wd, rd, acked);
      chk($sformatf("tbl%0d_ack", i), 32'(acked), 32'd1);
      if (!tbl[i].we) chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_out", i), 32'(io_out), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_oeb", i), 32'(io_oeb), 32'(tbl[i].exp_oeb));
    end
    chk("tbl_irq", 32'(irq), 32'h0);

    // Rising IRQ on pin 0: conditioned value after CL edges, irq two edges later
    @(posedge clk); #1; io_in[0] = 1'b1;
    for (int k = 1; k <= CL + 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rise_la_e%0d", k), 32'(la[0]), 32'(k >= CL));
      chk($sformatf("rise_irq0_e%0d", k), 32'(irq[0]), 32'(k >= CL + 2));
    end
    rd_chk("rise_istat", 8'h14, 32'h1);
    rd_chk("rise_in", 8'h08, 32'h1);
    wr(8'h14, 4'hF, 32'h1);
    @(posedge clk); #1;
    chk("w1c_irq", 32'(irq), 32'h0);
    rd_chk("w1c_istat", 8'h14, 32'h0);

    // Upper-half irq, and pending without enable on pin 5
    @(posedge clk); #1; io_in[15] = 1'b1; io_in[5] = 1'b1;
    repeat (CL + 3) @(posedge clk); #1;
    chk("hi_irq", 32'(irq), 32'b010);
    rd_chk("hi_istat", 8'h14, 32'h0000_8020);
    wr(8'h14, 4'hF, 32'h0000_FFFF);
    @(posedge clk); #1;
    chk("hi_clr_irq", 32'(irq), 32'h0);

    // Falling-mode pin 3 ignores its rise
    @(posedge clk); #1; io_in[3] = 1'b1;
    repeat (CL + 3) @(posedge clk);
    rd_chk("fall_norise", 8'h14, 32'h0);

    // Collision: W1C of bit 3 lands on the edge its falling event sets it
    @(posedge clk); #1; io_in[3] = 1'b0;
    repeat (CL) @(posedge clk);
    #1; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; sel = 4'hF; wdat = 32'h8;
    @(posedge clk); #1;
    chk("coll_ack", 32'(ack), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    $display("wb collision W1C adr=%h ack=%0d", BASE + 32'h14, ack);
    rd_chk("coll_istat", 8'h14, 32'h8);
    wr(8'h14, 4'hF, 32'h8);
    rd_chk("coll_clr", 8'h14, 32'h0);

    // Out-of-window access is never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h40; sel = 4'hF;
    n = 0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (ack) n++; end
    cyc = 1'b0; stb = 1'b0;
    chk("oob_acks", 32'(n), 32'd0);

    // Held request acks every other cycle
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    n = 0;
    for (int k = 0; k < 4; k++) begin @(posedge clk); #1; if (ack) n++; end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", 32'(n), 32'd2);

    // Write to IN: acked, value unchanged, error flag sets then clears via ISTAT[31]
    wr(8'h08, 4'hF, 32'h0000_FFFF);
    rd_chk("in_ro", 8'h08, 32'h0000_8021);
    chk("err_set", 32'(irq), 32'b100);
    wr(8'h14, 4'b1000, 32'h8000_0000);
    @(posedge clk); #1;
    chk("err_clr", 32'(irq), 32'h0);

`ifdef USER_GPIO_DEBOUNCE_EN
    // 5-cycle glitch is filtered; 10-cycle pulse passes after 2+8 cycles
    @(posedge clk); #1; io_in[2] = 1'b1;
    repeat (5) @(posedge clk); #1; io_in[2] = 1'b0;
    repeat (20) @(posedge clk); #1;
    chk("dbnc_glitch_la", 32'(la[2]), 32'd0);
    rd_chk("dbnc_glitch_istat", 8'h14, 32'h0);
    @(posedge clk); #1; io_in[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("dbnc_la_e%0d", k), 32'(la[2]), 32'(k >= 10));
    end
    io_in[2] = 1'b0;
    repeat (20) @(posedge clk);
`endif

    // Async reset mid-cycle with a pending write
    wr(8'h20, 4'hF, 32'h1);
    chk("err_unmapped", 32'(irq[2]), 32'd1);
    io_in = '0;
    repeat (CL + 2) @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h0000_FFFF;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out", 32'(io_out), 32'h0);
    chk("arst_oeb", 32'(io_oeb), 32'h0000_FFFF);
    chk("arst_irq", 32'(irq), 32'h0);
    chk("arst_ack", 32'(ack), 32'd0);
    repeat (2) @(posedge clk);
    #1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd_chk("arst_out_rd", 8'h00, 32'h0);
    rd_chk("arst_oeb_rd", 8'h04, 32'h0000_FFFF);
    rd_chk("arst_id", 8'h18, ID_EXP);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
